// File: rtl/piso_arb_ctrl.sv
// Two-requester round-robin front end for a PISO shifter: grants one word,
// pulses load/ack, then frames WIDTH serial bits followed by GAP idle cycles.
module piso_arb_ctrl #(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req,
  input  logic [WIDTH-1:0]           data0,
  input  logic [WIDTH-1:0]           data1,
  output logic [1:0]                 ack,
  output logic                       load,
  output logic [WIDTH-1:0]           parallel_in,
  output logic                       bit_valid,
  output logic [$clog2(WIDTH)-1:0]   bit_idx,
  output logic                       src_id,
  output logic                       busy,
  output logic                       done
);

  // state | meaning
  // IDLE  | waiting for a request; grants on the edge a req bit is seen
  // LOAD  | one cycle: load=1, ack to owner, parallel_in = held word
  // SHIFT | WIDTH cycles of frame bits, bit_idx 0..WIDTH-1
  // GAP   | GAP idle cycles before returning to IDLE
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold_word;
  logic [3:0]       gap_cnt;
  logic             last_grant;
  logic             grant_id;
  logic             last_bit;
  logic             gap_end;

  // A lone request always wins; on a tie the pointer hands it to the other side.
  assign grant_id = (req == 2'b11) ? ~last_grant : req[1];
  assign last_bit = (bit_idx == IDX_LAST);
  assign gap_end  = (gap_cnt == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = (GAP > 0) ? S_GAP : S_IDLE;
      S_GAP:   if (gap_end) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_word  <= '0;
      src_id     <= 1'b0;
      last_grant <= 1'b1;
      bit_idx    <= '0;
      gap_cnt    <= 4'd0;
      done       <= 1'b0;
    end else begin
      done <= (state == S_SHIFT) && last_bit;
      case (state)
        S_IDLE: begin
          if (|req) begin
            hold_word  <= grant_id ? data1 : data0;
            src_id     <= grant_id;
            last_grant <= grant_id;
          end
        end
        S_SHIFT: begin
          if (last_bit) begin
            bit_idx <= '0;
            gap_cnt <= GAP_LOAD;
          end else begin
            bit_idx <= bit_idx + 1'b1;
          end
        end
        S_GAP: begin
          if (!gap_end) gap_cnt <= gap_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // The hold register doubles as parallel_in so it keeps its value outside LOAD.
  assign parallel_in = hold_word;
  assign load        = (state == S_LOAD);
  assign ack         = {load & src_id, load & ~src_id};
  assign bit_valid   = (state == S_SHIFT);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Bench for piso_arb_ctrl: table of single grants, directed corner sequences,
// a GAP=0 instance, and random traffic against a word-timeline reference model.
module tb_piso_arb_ctrl;
  localparam int W = 4;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] data0, data1;
  logic [1:0] ack;
  logic       load, bit_valid, src_id, busy, done;
  logic [3:0] parallel_in;
  logic [1:0] bit_idx;

  logic [1:0] req_z;
  logic [3:0] data0_z, data1_z;
  logic [1:0] ack_z;
  logic       load_z, bit_valid_z, src_id_z, busy_z, done_z;
  logic [3:0] parallel_in_z;
  logic [1:0] bit_idx_z;

  int errors = 0;
  int checks = 0;

  piso_arb_ctrl #(.WIDTH(W), .GAP(G)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
    .ack(ack), .load(load), .parallel_in(parallel_in), .bit_valid(bit_valid),
    .bit_idx(bit_idx), .src_id(src_id), .busy(busy), .done(done)
  );

  piso_arb_ctrl #(.WIDTH(W), .GAP(0)) dut_z (
    .clk(clk), .rst(rst), .req(req_z), .data0(data0_z), .data1(data1_z),
    .ack(ack_z), .load(load_z), .parallel_in(parallel_in_z), .bit_valid(bit_valid_z),
    .bit_idx(bit_idx_z), .src_id(src_id_z), .busy(busy_z), .done(done_z)
  );

  always #5 clk = ~clk;

  // PISO attached to the main instance, MSB out first.
  logic [3:0] sh;
  always @(posedge clk or posedge rst) begin
    if (rst)            sh <= 4'd0;
    else if (load)      sh <= parallel_in;
    else if (bit_valid) sh <= {sh[2:0], 1'b0};
  end
  wire serial_out = sh[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00; data0 = 4'd0; data1 = 4'd0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_load(input int max_cyc);
    int n = 0;
    while (load !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_load", load, 1);
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] d0;
    logic [3:0] d1;
    logic       exp_src;
    logic [3:0] exp_word;
  } vec_t;
  vec_t tbl[8];

  // Reference model state: t = cycles since grant (-1 when idle).
  int         t;
  logic       m_src, m_last, m_done;
  logic [3:0] m_word;
  logic       pend[2];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    req_z = 2'b00; data0_z = 4'd0; data1_z = 4'd0;

    tbl[0] = '{2'b01, 4'h3, 4'hC, 1'b0, 4'h3};
    tbl[1] = '{2'b11, 4'h1, 4'hE, 1'b1, 4'hE};
    tbl[2] = '{2'b11, 4'h7, 4'h8, 1'b0, 4'h7};
    tbl[3] = '{2'b10, 4'h0, 4'h9, 1'b1, 4'h9};
    tbl[4] = '{2'b10, 4'h5, 4'hC, 1'b1, 4'hC};
    tbl[5] = '{2'b11, 4'h6, 4'h2, 1'b0, 4'h6};
    tbl[6] = '{2'b01, 4'hB, 4'h4, 1'b0, 4'hB};
    tbl[7] = '{2'b11, 4'h4, 4'hD, 1'b1, 4'hD};

    // Reset values, then first word 1101 streamed MSB first.
    rst = 1'b1; req = 2'b01; data0 = 4'b1101; data1 = 4'd0;
    @(negedge clk);
    #1;
    check("rst_ack", ack, 0);         check("rst_load", load, 0);
    check("rst_pin", parallel_in, 0); check("rst_bv", bit_valid, 0);
    check("rst_idx", bit_idx, 0);     check("rst_src", src_id, 0);
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("no_grant_before_edge", load, 0);
    @(negedge clk);
    check("w1_load", load, 1); check("w1_pin", parallel_in, 4'b1101);
    check("w1_ack", ack, 2'b01); check("w1_busy", busy, 1);
    req = 2'b00;
    for (int i = 0; i < W; i++) begin
      logic [3:0] pat;
      pat = 4'b1101;
      @(negedge clk);
      check("w1_bv", bit_valid, 1);
      check("w1_idx", bit_idx, i);
      check("w1_serial", serial_out, pat[3-i]);
      check("w1_load_low", load, 0);
    end
    @(negedge clk);
    check("w1_done", done, 1); check("w1_bv_gap", bit_valid, 0); check("w1_idx_gap", bit_idx, 0);
    @(negedge clk);
    check("w1_done_pulse", done, 0); check("w1_idle", busy, 0);

    // Table of single grants from IDLE, starting with a fresh pointer.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      req = tbl[k].req; data0 = tbl[k].d0; data1 = tbl[k].d1;
      @(negedge clk);
      check("tbl_load", load, 1);
      check("tbl_src", src_id, tbl[k].exp_src);
      check("tbl_ack", ack, tbl[k].exp_src ? 2'b10 : 2'b01);
      check("tbl_word", parallel_in, tbl[k].exp_word);
      req = 2'b00; data0 = 4'($urandom); data1 = 4'($urandom);
      repeat (W) @(negedge clk);
      check("tbl_last_idx", bit_idx, W - 1);
      check("tbl_word_held", parallel_in, tbl[k].exp_word);
      check("tbl_src_held", src_id, tbl[k].exp_src);
      @(negedge clk);
      check("tbl_done", done, 1); check("tbl_gap_busy", busy, 1);
      @(negedge clk);
      check("tbl_idle", busy, 0);
    end

    // Continuous tie: alternating grants, LOAD every 7 cycles.
    begin
      int lc[$];
      logic ls[$];
      logic [3:0] lw[$];
      do_reset();
      req = 2'b11; data0 = 4'hA; data1 = 4'h5;
      for (int c = 1; c <= 26; c++) begin
        @(negedge clk);
        if (load) begin lc.push_back(c); ls.push_back(src_id); lw.push_back(parallel_in); end
      end
      check("tie_count", lc.size(), 4);
      if (lc.size() >= 4) begin
        for (int k = 0; k < 4; k++) begin
          check("tie_src", ls[k], k % 2);
          check("tie_word", lw[k], (k % 2) ? 4'h5 : 4'hA);
          if (k > 0) check("tie_period", lc[k] - lc[k-1], 7);
        end
      end
      req = 2'b00;
    end

    // Data change during SHIFT must not disturb the word in flight.
    do_reset();
    req = 2'b01; data0 = 4'hF;
    @(negedge clk);
    check("hold_load_F", parallel_in, 4'hF);
    @(negedge clk);
    data0 = 4'h0;
    repeat (3) begin
      @(negedge clk);
      check("hold_pin_F", parallel_in, 4'hF);
    end
    @(negedge clk);
    wait_load(10);
    check("hold_next_word", parallel_in, 4'h0);
    req = 2'b00;
    repeat (W + 2) @(negedge clk);

    // Reset at bit_idx=2: immediate reset values, no done, pointer back to 1.
    do_reset();
    req = 2'b01; data0 = 4'h9;
    @(negedge clk);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("abort_idx2", bit_idx, 2);
    #1 rst = 1'b1;
    #1;
    check("abort_ack", ack, 0);         check("abort_load", load, 0);
    check("abort_pin", parallel_in, 0); check("abort_bv", bit_valid, 0);
    check("abort_idx", bit_idx, 0);     check("abort_src", src_id, 0);
    check("abort_busy", busy, 0);       check("abort_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
      check("abort_idle", busy, 0);
    end
    req = 2'b11; data0 = 4'h1; data1 = 4'h2;
    @(negedge clk);
    check("abort_tie_load", load, 1);
    check("abort_tie_src", src_id, 0);
    check("abort_tie_ack", ack, 2'b01);
    req = 2'b00;
    repeat (W + 2) @(negedge clk);

    // A request withdrawn before any edge sees it is ignored.
    req = 2'b10; data1 = 4'h7;
    #2 req = 2'b00;
    repeat (5) begin
      @(negedge clk);
      check("drop_load", load, 0);
      check("drop_ack", ack, 0);
      check("drop_busy", busy, 0);
    end

    // Random traffic against the word-timeline model.
    do_reset();
    t = -1; m_src = 1'b0; m_last = 1'b1; m_done = 1'b0; m_word = 4'd0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic bv;
      bv = (t >= 1) && (t <= W);
      check("rnd_load", load, t == 0);
      check("rnd_ack", ack, (t == 0) ? (m_src ? 2'b10 : 2'b01) : 2'b00);
      check("rnd_bv", bit_valid, bv);
      check("rnd_idx", bit_idx, bv ? t - 1 : 0);
      check("rnd_busy", busy, t >= 0);
      check("rnd_done", done, m_done);
      check("rnd_pin", parallel_in, m_word);
      check("rnd_src", src_id, m_src);
      for (int i = 0; i < 2; i++) begin
        if (t == 0 && m_src == i[0]) begin
          pend[i] = 1'b0;
        end else if (!pend[i]) begin
          if ($urandom_range(0, 3) == 0) pend[i] = 1'b1;
          if (i == 0) data0 = 4'($urandom); else data1 = 4'($urandom);
        end else if ($urandom_range(0, 39) == 0) begin
          pend[i] = 1'b0;
        end
      end
      req = {pend[1], pend[0]};
      @(posedge clk);
      m_done = (t == W);
      if (t < 0) begin
        if (req != 2'b00) begin
          m_src  = (req == 2'b11) ? ~m_last : (req == 2'b10);
          m_last = m_src;
          m_word = m_src ? data1 : data0;
          t = 0;
        end
      end else begin
        t++;
        if (t > W + G) t = -1;
      end
      @(negedge clk);
    end
    req = 2'b00;

    // GAP=0 instance with req=10 held: 6-cycle period, one IDLE cycle with done.
    req_z = 2'b10; data1_z = 4'h6;
    for (int c = 1; c <= 20; c++) begin
      int p;
      @(negedge clk);
      p = (c - 1) % 6;
      check("g0_load", load_z, p == 0);
      check("g0_bv", bit_valid_z, (p >= 1) && (p <= 4));
      check("g0_done", done_z, (c > 1) && (p == 5));
      if (p == 0) begin
        check("g0_ack", ack_z, 2'b10);
        check("g0_src", src_id_z, 1);
        check("g0_word", parallel_in_z, 4'h6);
      end
      if (p >= 1 && p <= 4) begin
        check("g0_idx", bit_idx_z, p - 1);
        check("g0_busy", busy_z, 1);
      end
    end
    req_z = 2'b00;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
